// File: rtl/display_alternator.sv
// display_alternator: alternates a two-view display between water-level and irrigation,
// blanking the digits while the 2:1 selector changes.
module display_alternator #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter int CNT_W        = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic freeze_i,
  input  logic force_irr_i,
  output logic selector_o,
  output logic blank_o,
  output logic switch_o
);
  typedef enum logic [1:0] {LEVEL, GAP_TO_IRR, IRR, GAP_TO_LEVEL} state_t;
  localparam bit NO_GAP = BLANK_CYCLES == 0;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(NO_GAP ? 0 : BLANK_CYCLES - 1);
  state_t state_q, state_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sel_q, blank_q, sw_q, sw_d, dwell, expire;
  always_comb begin
    dwell  = state_q == LEVEL || state_q == IRR;
    expire = cnt_q == (dwell ? DWELL_LAST : BLANK_LAST);
    nxt    = state_q == LEVEL      ? (NO_GAP ? IRR : GAP_TO_IRR) :
             state_q == GAP_TO_IRR ? IRR :
             state_q == IRR        ? (NO_GAP ? LEVEL : GAP_TO_LEVEL) : LEVEL;
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sw_d    = 1'b0;
    if (!enable_i) begin
      state_d = LEVEL;
      cnt_d   = '0;
    end else if (freeze_i) begin
      cnt_d = cnt_q;
    end else if (force_irr_i && state_q == LEVEL) begin
      state_d = NO_GAP ? IRR : GAP_TO_IRR;
      cnt_d   = '0;
      sw_d    = NO_GAP;
    end else if (force_irr_i && state_q == IRR) begin
      cnt_d = '0;
    end else if (expire) begin
      state_d = nxt;
      cnt_d   = '0;
      sw_d    = nxt == LEVEL || nxt == IRR;
    end
  end
  // outputs are decoded from the next state so they stay registered yet aligned with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LEVEL;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      blank_q <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= state_d == GAP_TO_IRR || state_d == IRR;
      blank_q <= state_d == GAP_TO_IRR || state_d == GAP_TO_LEVEL;
      sw_q    <= sw_d;
    end
  end
  assign selector_o = sel_q;
  assign blank_o    = blank_q;
  assign switch_o   = sw_q;
endmodule

// File: doc/display_alternator.md
DISPLAY_ALTERNATOR -- requirements
Module: display_alternator

Interface
REQ-001 The module SHALL have parameter DWELL_CYCLES, default 50_000_000: clock cycles each view is shown; legal values are 1 or more.
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 1_000: blanked cycles between views; 0 is legal.
REQ-003 The module SHALL have parameter CNT_W, default 26: dwell/blank counter width; it SHALL be large enough to hold max(DWELL_CYCLES, BLANK_CYCLES) - 1.
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset:
- clk_i  input  1  sole clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have these control inputs:
- enable_i  input  1  alternation enable.
- freeze_i  input  1  hold the current state and count.
- force_irr_i  input  1  single-cycle request to show the irrigation view now.
REQ-006 The module SHALL have these outputs:
- selector_o  output  1  0 = water-level view, 1 = irrigation view; drives the display 2:1 selector.
- blank_o  output  1  1 = display digits off.
- switch_o  output  1  one-cycle pulse marking the start of a view.

Function
REQ-007 The FSM SHALL have four states: LEVEL, GAP_TO_IRR, IRR and GAP_TO_LEVEL.
REQ-008 All outputs SHALL be registered, and SHALL take these values (selector_o / blank_o):
- LEVEL: 0/0.
- GAP_TO_IRR: 1/1.
- IRR: 1/0.
- GAP_TO_LEVEL: 0/1.
- Effect: the selector changes only while the display is blanked.
REQ-009 The counter SHALL clear to 0 on every state entry, and SHALL increment by 1 on each cycle where enable_i=1, freeze_i=0 and no transition occurs.
REQ-010 The FSM SHALL transition as follows:
- LEVEL→GAP_TO_IRR when the counter equals DWELL_CYCLES-1.
- GAP_TO_IRR→IRR when the counter equals BLANK_CYCLES-1.
- IRR→GAP_TO_LEVEL when the counter equals DWELL_CYCLES-1.
- GAP_TO_LEVEL→LEVEL when the counter equals BLANK_CYCLES-1.
REQ-011 When BLANK_CYCLES=0, the gap states SHALL be skipped: LEVEL↔IRR directly, and blank_o stays 0.
REQ-012 switch_o SHALL be 1 for exactly the first cycle of each LEVEL or IRR visit that results from a transition, and 0 otherwise.
REQ-013 With enable_i=0, the next state SHALL be LEVEL with counter 0; switch_o SHALL stay 0 when this forced return occurs.
REQ-014 With enable_i=1 and freeze_i=1, the state, the counter and all outputs SHALL hold (switch_o SHALL be 0).
REQ-015 force_irr_i SHALL act only when enable_i=1 and freeze_i=0, as follows:
- In LEVEL: enter GAP_TO_IRR, or IRR if BLANK_CYCLES=0, with counter 0.
- In IRR: restart the dwell counter at 0, with no switch_o pulse.
- In a gap state: ignored.
REQ-016 Priority SHALL be enable_i=0 > freeze_i=1 > force_irr_i > dwell/blank expiry.
REQ-017 With DWELL_CYCLES=1, each view SHALL last exactly one cycle; the counter SHALL never exceed its terminal value.
REQ-018 The steady alternation period SHALL be 2×(DWELL_CYCLES+BLANK_CYCLES) cycles.

Reset
REQ-019 While rst_i=1, asynchronously: state=LEVEL, counter=0, selector_o=0, blank_o=0, switch_o=0.
REQ-020 After rst_i deasserts, operation SHALL resume at the first rising clk_i edge with enable_i=1, counting from 0 in LEVEL.
REQ-021 An rst_i assertion mid-gap or mid-dwell SHALL immediately force blank_o=0 and selector_o=0 without waiting for a clock edge.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2 unless stated)
REQ-022 Bench SHALL cover steady alternation: reset, then enable_i=1 held → selector_o/blank_o SHALL be 0/0 for 4 cycles, 1/1 for 2, 1/0 for 4 (switch_o=1 on the first of these), 0/1 for 2, then 0/0 with switch_o=1; period 12.
REQ-023 Bench SHALL cover freeze: freeze_i=1 for 5 cycles during the 2nd cycle of GAP_TO_IRR → blank_o=1 and selector_o=1 held for 5 cycles, then exactly 1 more gap cycle, then IRR.
REQ-024 Bench SHALL cover force:
- force_irr_i pulse on LEVEL counter=1 → GAP_TO_IRR on the next cycle.
- A second pulse on IRR counter=2 → IRR lasts 4 cycles counted from that pulse, with no extra switch_o.
REQ-025 Bench SHALL cover disable: enable_i=0 during IRR counter=3 → LEVEL, selector_o=0, blank_o=0 next cycle, switch_o=0; re-enable → 4 LEVEL cycles before the gap.
REQ-026 Bench SHALL cover no-blank operation: BLANK_CYCLES=0, DWELL_CYCLES=1 → selector_o toggles every cycle, blank_o constantly 0, switch_o constantly 1 after the first transition.
REQ-027 Bench SHALL cover asynchronous reset: rst_i asserted between clock edges during GAP_TO_LEVEL → outputs 0/0/0 before the next edge; with enable_i=1 held, 4 LEVEL cycles follow release.
